// File: rtl/full_adder_pkg.sv
// Shared constants for the full_adder slice.
// Defines the legal operand width bound for the adder.
package full_adder_pkg;

  localparam int FA_MAX_WIDTH = 64;

endpackage : full_adder_pkg

// File: rtl/fa_cell.sv
// One-bit combinational full adder.
// This is the leaf cell of the ripple chain.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ ci;
  assign carry = (a & b) | (a & ci) | (b & ci);

endmodule : fa_cell

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder built from fa_cell leaves.
// Has an optional single output register stage with asynchronous active-low clear.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH        = 1,
  parameter bit REGISTER_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  if ((WIDTH < 1) || (WIDTH > FA_MAX_WIDTH)) begin : gWidthCheck
    $error("full_adder: WIDTH=%0d outside 1..%0d", WIDTH, FA_MAX_WIDTH);
  end

  logic [WIDTH:0]   chain;
  logic [WIDTH-1:0] sum_d;
  logic             carry_d;

  assign chain[0] = ci;

  for (genvar i = 0; i < WIDTH; i++) begin : gCell
    fa_cell uCell (
      .a    (a[i]),
      .b    (b[i]),
      .ci   (chain[i]),
      .sum  (sum_d[i]),
      .carry(chain[i+1])
    );
  end

  assign carry_d = chain[WIDTH];

  if (REGISTER_OUT) begin : gReg
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;

    // Reset clears the stage immediately, discarding any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q   <= '0;
        carry_q <= 1'b0;
      end else begin
        sum_q   <= sum_d;
        carry_q <= carry_d;
      end
    end

    assign sum   = sum_q;
    assign carry = carry_q;
  end else begin : gComb
    assign sum   = sum_d;
    assign carry = carry_d;
  end

endmodule : full_adder

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: registered WIDTH=1 and WIDTH=8 instances
// plus a combinational WIDTH=1 instance, compared against plain integer addition.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rstComb = 1'b0;

  logic       a1, b1, ci1;
  logic       sum1, carry1;
  logic [7:0] a8, b8;
  logic       ci8;
  logic [7:0] sum8;
  logic       carry8;
  logic       aC, bC, ciC;
  logic       sumC, carryC;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1), .REGISTER_OUT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .ci(ci1), .sum(sum1), .carry(carry1)
  );

  full_adder #(.WIDTH(8), .REGISTER_OUT(1'b1)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .ci(ci8), .sum(sum8), .carry(carry8)
  );

  full_adder #(.WIDTH(1), .REGISTER_OUT(1'b0)) dutComb (
    .clk(clk), .rst_n(rstComb), .a(aC), .b(bC), .ci(ciC), .sum(sumC), .carry(carryC)
  );

  // Reference: the whole (WIDTH+1)-bit unsigned sum as ordinary integers.
  function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    int unsigned total;
    total = int'(a) + int'(b) + int'(ci);
    return total[8:0];
  endfunction

  function automatic logic [1:0] model1(input logic a, input logic b, input logic ci);
    int unsigned total;
    total = int'(a) + int'(b) + int'(ci);
    return total[1:0];
  endfunction

  task automatic applyStimulus1(input logic a, input logic b, input logic ci);
    a1  = a;
    b1  = b;
    ci1 = ci;
  endtask

  task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    a8  = a;
    b8  = b;
    ci8 = ci;
  endtask

  task automatic test_reset();
    applyStimulus1(1'b0, 1'b0, 1'b0);
    applyStimulus8(8'h00, 8'h00, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({carry1, sum1} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_async_w1: got %b, expected 00", {carry1, sum1});
    end
    checks++;
    if ({carry8, sum8} !== 9'h000) begin
      errors++;
      $display("[TB] FAIL reset_async_w8: got %h, expected 000", {carry8, sum8});
    end
    // Hold reset across edges with nonzero inputs; outputs must stay cleared.
    applyStimulus1(1'b1, 1'b1, 1'b1);
    applyStimulus8(8'hFF, 8'hFF, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if ({carry1, sum1} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_hold_w1: got %b, expected 00", {carry1, sum1});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({carry1, sum1} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL reset_first_capture: got %b, expected 11", {carry1, sum1});
    end
    // Mid-cycle reset assertion clears outputs with no clock edge.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({carry1, sum1} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_midcycle_w1: got %b, expected 00", {carry1, sum1});
    end
    checks++;
    if ({carry8, sum8} !== 9'h000) begin
      errors++;
      $display("[TB] FAIL reset_midcycle_w8: got %h, expected 000", {carry8, sum8});
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({carry1, sum1} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_midcycle_hold: got %b, expected 00", {carry1, sum1});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({carry1, sum1} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL reset_release_capture: got %b, expected 11", {carry1, sum1});
    end
  endtask

  task automatic test_exhaustive_w1();
    logic [2:0]  vec;
    logic [1:0]  expected;
    for (int i = 0; i < 8; i++) begin
      vec = 3'(i);
      @(negedge clk);
      applyStimulus1(vec[2], vec[1], vec[0]);
      expected = model1(vec[2], vec[1], vec[0]);
      @(negedge clk);
      checks++;
      if ({carry1, sum1} !== expected) begin
        errors++;
        $display("[TB] FAIL exhaustive_w1 abc=%b: got %b, expected %b", vec, {carry1, sum1}, expected);
      end
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    applyStimulus1(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #1 applyStimulus1(1'b1, 1'b0, 1'b0);
    #2;
    checks++;
    if ({carry1, sum1} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL latency_before_edge: got %b, expected 00", {carry1, sum1});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({carry1, sum1} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL latency_after_edge: got %b, expected 01", {carry1, sum1});
    end
  endtask

  task automatic test_ripple_w8();
    @(negedge clk);
    applyStimulus8(8'hFF, 8'h00, 1'b1);
    @(negedge clk);
    checks++;
    if ({carry8, sum8} !== 9'h100) begin
      errors++;
      $display("[TB] FAIL ripple_ff_00_1: got %h, expected 100", {carry8, sum8});
    end
    applyStimulus8(8'hFF, 8'hFF, 1'b1);
    @(negedge clk);
    checks++;
    if ({carry8, sum8} !== 9'h1FF) begin
      errors++;
      $display("[TB] FAIL ripple_ff_ff_1: got %h, expected 1ff", {carry8, sum8});
    end
    applyStimulus8(8'h00, 8'h00, 1'b0);
    @(negedge clk);
    checks++;
    if ({carry8, sum8} !== 9'h000) begin
      errors++;
      $display("[TB] FAIL ripple_zero: got %h, expected 000", {carry8, sum8});
    end
  endtask

  // Back-to-back random vectors: a new operand set every cycle on both widths.
  task automatic test_back_to_back_random();
    logic [8:0] exp8;
    logic [1:0] exp1;
    logic [7:0] ra, rb;
    logic       rc, r1a, r1b, r1c;
    @(negedge clk);
    for (int n = 0; n < 1000; n++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rc  = 1'($urandom);
      r1a = 1'($urandom);
      r1b = 1'($urandom);
      r1c = 1'($urandom);
      applyStimulus8(ra, rb, rc);
      applyStimulus1(r1a, r1b, r1c);
      exp8 = model8(ra, rb, rc);
      exp1 = model1(r1a, r1b, r1c);
      @(negedge clk);
      checks++;
      if ({carry8, sum8} !== exp8) begin
        errors++;
        $display("[TB] FAIL random_w8 #%0d a=%h b=%h ci=%b: got %h, expected %h",
                 n, ra, rb, rc, {carry8, sum8}, exp8);
      end
      checks++;
      if ({carry1, sum1} !== exp1) begin
        errors++;
        $display("[TB] FAIL random_w1 #%0d: got %b, expected %b", n, {carry1, sum1}, exp1);
      end
    end
  endtask

  task automatic test_combinational();
    logic [1:0] expected;
    logic [2:0] vec;
    aC = 1'b1; bC = 1'b1; ciC = 1'b0;
    #1;
    checks++;
    if ({carryC, sumC} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL comb_110: got %b, expected 10", {carryC, sumC});
    end
    for (int i = 0; i < 16; i++) begin
      vec = 3'($urandom);
      aC = vec[2]; bC = vec[1]; ciC = vec[0];
      expected = model1(vec[2], vec[1], vec[0]);
      #1;
      checks++;
      if ({carryC, sumC} !== expected) begin
        errors++;
        $display("[TB] FAIL comb_random abc=%b: got %b, expected %b", vec, {carryC, sumC}, expected);
      end
    end
  endtask

  initial begin
    aC = 1'b0; bC = 1'b0; ciC = 1'b0;
    test_reset();
    test_exhaustive_w1();
    test_latency();
    test_ripple_w8();
    test_back_to_back_random();
    test_combinational();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_full_adder
